array_18_ctrl: RTL and testbench
================================

# array_18_ctrl

Request/response front end that drives the 1024 x 180-bit single-port SRAM macro (ten 18-bit write lanes, one-cycle registered read). It turns a valid/ready request stream into SRAM `en/wmode/wmask` strobes, absorbs the macro's read latency, and buffers read data in a 2-entry response queue so consumers can apply backpressure. It sits directly upstream of the array macro, between the array client and the memory.

## Interface
- `ADDR_W`, 10, address width (depth 1024)
- `LANES`, 10, write-mask lanes
- `LANE_W`, 18, bits per lane; data width = `LANES*LANE_W` = 180
- `clock  in  1  sole clock, all state on rising edge`
- `reset_n  in  1  asynchronous, active-low reset`
- `req_valid  in  1  request present`
- `req_ready  out  1  request accepted when valid && ready (fire)`
- `req_write  in  1  1 = masked write, 0 = read`
- `req_addr  in  10  word address`
- `req_mask  in  10  per-lane write enable (writes only)`
- `req_wdata  in  180  write data`
- `resp_valid  out  1  read data available`
- `resp_ready  in  1  consumer takes head response`
- `resp_rdata  out  180  read data, head of queue`
- `init_done  out  1  block is in READY`
- `mem_en, mem_wmode  out  1 each  SRAM enable / write mode`
- `mem_addr  out  10`; `mem_wmask  out  10`; `mem_wdata  out  180`
- `mem_rdata  in  180  SRAM read data, valid the cycle after a read strobe`

## Operation
- States: WAIT (reset value), CLEAR (only with macro), READY. WAIT -> CLEAR or READY on the first edge after `reset_n` rises. CLEAR -> READY after address 1023 is written.
- In READY, SRAM strobes are combinational from the request: `mem_en = fire`, `mem_wmode = req_write`, `mem_addr = req_addr`, `mem_wdata = req_wdata`, `mem_wmask = req_write ? req_mask : 0`. Outside fire, `mem_en = 0`.
- `pop = resp_valid && resp_ready`. `req_ready = (state==READY) && (occ + inflight - pop < 2)`, where `occ` is queue occupancy (0..2) and `inflight` is 1 if a read fired last cycle. Readiness does not depend on `req_valid` or `req_write`.
- A read fire sets `inflight` for the next cycle. In that cycle `mem_rdata` is pushed into the queue. Push and pop in the same cycle leave `occ` unchanged. The accounting makes overflow impossible. Any push into a full queue is a design error and is flagged by an assertion.
- Writes produce no response. A write with mask 0 still strobes `mem_en` and is harmless.
- Responses return in request order.

## Timing
- Reset values: `req_ready=0`, `resp_valid=0`, `init_done=0`, `mem_en=0`, `resp_rdata=0`, occ=0, inflight=0.
- Read latency: fire at edge N, data sampled into the queue at edge N+1, `resp_valid=1` during cycle N+1..N+2 boundary (visible after edge N+1). Total: 2 edges from fire to response available.
- Throughput: 1 read/cycle sustained while `resp_ready=1`. With `resp_ready=0`, at most 2 reads are outstanding (queue plus in flight), then `req_ready=0`.
- Reset asserted mid-operation: queue, `inflight`, and FSM clear immediately. In-flight read data is dropped. Any clear in progress is restarted after reset.

## Configuration
- `ARRAY_18_INIT_CLEAR_EN` defined: WAIT -> CLEAR. CLEAR issues 1024 consecutive writes (addr 0..1023, `mem_wmask` all ones, `mem_wdata` 0), one per cycle. `req_ready=0` throughout. `init_done` rises on the cycle after the write to address 1023, which is 1025 edges after reset release.
- Not defined: no CLEAR state and no address counter. WAIT -> READY, so `init_done=1` and `req_ready` may be 1 after the first edge. SRAM contents are not initialised.

## Structure
- `array_18_pkg`: `ADDR_W`, `LANES`, `LANE_W`, `DATA_W`, `DEPTH=1024`, state enum {WAIT, CLEAR, READY}.
- Sub-module `array_18_resp_fifo`: 2-entry, 180-bit, push/pop/occ, async active-low reset, same-cycle push+pop allowed.

## Test plan
- Reset release with macro on -> exactly 1024 `mem_en` write strobes, addr 0..1023, mask 0x3FF, data 0. `init_done` rises 1025 edges after release. No `req_ready` before that.
- Write addr 5, mask 0x001, data lane0=0x2AAAA, then read addr 5 -> `resp_rdata[17:0]=0x2AAAA`, `resp_valid` 2 edges after the read fire.
- Back-to-back reads of addr 1,2,3,4 with `resp_ready=1` -> one fire per cycle, responses in order 1,2,3,4 on 4 consecutive cycles.
- `resp_ready=0` with 4 reads offered -> only 2 fire and `req_ready` drops. Raising `resp_ready` drains both, then the remaining reads fire.
- Read fires, then `reset_n` is pulsed low the next cycle -> no `resp_valid` after reset, occ=0, WAIT re-entered.
- Macro off -> `init_done=1` and `req_ready=1` after the first edge post-reset, with zero CLEAR strobes.

Source files
------------

// File: rtl/array_18_pkg.sv
// -----------------------------------------------------------------------------
// array_18_pkg
//   Shared constants and types for the array_18 SRAM front end.
//   ADDR_W/LANES/LANE_W describe the 1024 x 180-bit macro (ten 18-bit lanes).
//   ctrl_state_t is the controller FSM state set.
//   The build macro ARRAY_18_INIT_CLEAR_EN (used by array_18_ctrl) enables
//   the post-reset CLEAR sweep.
// -----------------------------------------------------------------------------
package array_18_pkg;

    localparam int ADDR_W = 10;
    localparam int LANES  = 10;
    localparam int LANE_W = 18;
    localparam int DATA_W = LANES * LANE_W;
    localparam int DEPTH  = 1024;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } ctrl_state_t;

    // Reads must never present a lane mask to the macro.
    function automatic logic [LANES-1:0] write_mask(input logic             is_write,
                                                    input logic [LANES-1:0] mask);
        return is_write ? mask : '0;
    endfunction

endpackage

// File: rtl/array_18_resp_fifo.sv
// -----------------------------------------------------------------------------
// array_18_resp_fifo
//   Two-entry response queue holding read data returned by the SRAM macro.
//   Push and pop in the same cycle are allowed and leave occupancy unchanged.
//
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   push_i       write push_data_i into the tail
//   push_data_i  read data from the macro
//   pop_i        discard the head entry
//   head_o       head entry (zero after reset)
//   occ_o        occupancy, 0..2
// -----------------------------------------------------------------------------
module array_18_resp_fifo
    import array_18_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        occ_o
);

    logic [DATA_W-1:0] slot_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= '0;
        end else begin
            // When full, wr_ptr == rd_ptr: a simultaneous push+pop overwrites
            // the slot whose contents are being consumed on this same edge.
            if (push_i) begin
                slot_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_o = slot_q[rd_ptr_q];
    assign occ_o  = occ_q;

    // Upstream credit accounting guarantees neither of these can happen.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && (occ_q == 2'd2)))
        else $error("array_18_resp_fifo: push into full queue");

    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && (occ_q == 2'd0)))
        else $error("array_18_resp_fifo: pop from empty queue");

endmodule

// File: rtl/array_18_ctrl.sv
// -----------------------------------------------------------------------------
// array_18_ctrl
//   Request/response front end for the 1024 x 180-bit single-port SRAM macro.
//   Converts a valid/ready request stream into macro en/wmode/wmask strobes,
//   absorbs the one-cycle registered read latency and buffers read data in a
//   2-entry response queue so the consumer can apply backpressure.
//
//   Build option: define ARRAY_18_INIT_CLEAR_EN to zero the whole array
//   (1024 full-mask writes) after every reset before accepting requests.
//
//   clock       sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   req_*       request channel (valid/ready, write, addr, mask, wdata)
//   resp_*      response channel (valid/ready, rdata = head of queue)
//   init_done   high while the controller is in READY
//   mem_*       SRAM macro strobes; mem_rdata valid the cycle after a read
// -----------------------------------------------------------------------------
module array_18_ctrl
    import array_18_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_mask,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,

    output logic              init_done,

    output logic              mem_en,
    output logic              mem_wmode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    ctrl_state_t state_q;
    logic        init_done_q;
    logic        inflight_q;
    logic        fire;
    logic        pop;
    logic [1:0]  occ;

`ifdef ARRAY_18_INIT_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr_q;
`endif

    // -------------------------------------------------------------------------
    // Handshake and credit accounting
    // -------------------------------------------------------------------------
    assign pop        = resp_valid && resp_ready;
    assign resp_valid = (occ != 2'd0);

    // occ + inflight - pop < 2, rearranged as occ + inflight < 2 + pop so the
    // unsigned arithmetic never wraps.
    assign req_ready = (state_q == READY) &&
                       (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    assign fire      = req_valid && req_ready;
    assign init_done = init_done_q;

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT;
            init_done_q <= 1'b0;
`ifdef ARRAY_18_INIT_CLEAR_EN
            clr_addr_q  <= '0;
`endif
        end else begin
            case (state_q)
                WAIT: begin
`ifdef ARRAY_18_INIT_CLEAR_EN
                    state_q    <= CLEAR;
                    clr_addr_q <= '0;
`else
                    state_q     <= READY;
                    init_done_q <= 1'b1;
`endif
                end
                CLEAR: begin
`ifdef ARRAY_18_INIT_CLEAR_EN
                    // The strobe for clr_addr_q is issued this cycle; leave
                    // once the last word has been written.
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
`else
                    state_q <= WAIT;
`endif
                end
                READY: begin
                    state_q     <= READY;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= WAIT;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read-latency tracking: a read fired last cycle returns data now.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fire && !req_write;
        end
    end

    // -------------------------------------------------------------------------
    // SRAM strobes
    // -------------------------------------------------------------------------
    always_comb begin
        mem_en    = fire;
        mem_wmode = req_write;
        mem_addr  = req_addr;
        mem_wmask = write_mask(req_write, req_mask);
        mem_wdata = req_wdata;
`ifdef ARRAY_18_INIT_CLEAR_EN
        // req_ready is low in CLEAR, so this never competes with a request.
        if (state_q == CLEAR) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wmask = '1;
            mem_wdata = '0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Response queue
    // -------------------------------------------------------------------------
    array_18_resp_fifo u_resp_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .push_i      (inflight_q),
        .push_data_i (mem_rdata),
        .pop_i       (pop),
        .head_o      (resp_rdata),
        .occ_o       (occ)
    );

endmodule

// File: tb/tb_array_18_ctrl.sv
// -----------------------------------------------------------------------------
// tb_array_18_ctrl
//   Self-checking bench for array_18_ctrl. Includes a behavioural SRAM macro,
//   a lane-merging reference memory and an expected-response queue.
//   Honours ARRAY_18_INIT_CLEAR_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_array_18_ctrl;
    import array_18_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_mask;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid, resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic              mem_en, mem_wmode;
    logic [ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_wmask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    array_18_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_mask   (req_mask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .mem_en     (mem_en),
        .mem_wmode  (mem_wmode),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- behavioural SRAM macro ----------------
    logic [DATA_W-1:0] sram [DEPTH];
    logic [DATA_W-1:0] sram_w;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                sram_w = sram[mem_addr];
                for (int l = 0; l < LANES; l++)
                    if (mem_wmask[l]) sram_w[l*LANE_W +: LANE_W] = mem_wdata[l*LANE_W +: LANE_W];
                sram[mem_addr] <= sram_w;
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] obs_q [$];
    int unsigned       fire_cyc_q [$];
    int unsigned       pop_cyc_q [$];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
    end

    // Sampled mid-cycle: records accepted requests and consumed responses.
    always @(negedge clock) begin
        if (reset_n) begin
            if (req_valid && req_ready) begin
                if (req_write) begin
                    for (int l = 0; l < LANES; l++)
                        if (req_mask[l])
                            ref_mem[req_addr][l*LANE_W +: LANE_W] = req_wdata[l*LANE_W +: LANE_W];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    fire_cyc_q.push_back(cyc);
                end
            end
            if (resp_valid && resp_ready) begin
                obs_q.push_back(resp_rdata);
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int l = 0; l < LANES; l++) d[l*LANE_W +: LANE_W] = LANE_W'($urandom);
        return d;
    endfunction

    task automatic flush_model();
        exp_q.delete();
        obs_q.delete();
        fire_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    // Holds a request until it fires; returns #1 after the firing edge.
    task automatic drive_one(input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
        bit fired = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_mask  = m;
        req_wdata = d;
        for (int i = 0; i < 64 && !fired; i++) begin
            @(negedge clock);
            fired = req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        checks++;
        if (!fired) begin
            failures++;
            $display("FAIL drive_timeout: request addr=%0d never accepted (got ready=0, expected 1)", a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_mask   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (req_ready !== 1'b0)  begin failures++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (init_done !== 1'b0)  begin failures++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        checks++; if (mem_en !== 1'b0)     begin failures++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        checks++; if (resp_rdata !== '0)   begin failures++; $display("FAIL reset_resp_rdata: got %0h expected 0", resp_rdata); end
    endtask

    task automatic test_init_release();
`ifdef ARRAY_18_INIT_CLEAR_EN
        int unsigned strobes = 0, bad = 0, early_ready = 0, done_edge = 0;
        reset_n = 1'b1;
        for (int unsigned e = 1; e <= 1100 && done_edge == 0; e++) begin
            @(negedge clock);
            if (mem_en) begin
                if (mem_addr !== ADDR_W'(strobes) || mem_wmask !== '1 ||
                    mem_wdata !== '0 || mem_wmode !== 1'b1) bad++;
                strobes++;
            end
            if (req_ready) early_ready++;
            @(posedge clock);
            #1;
            if (init_done === 1'b1) done_edge = e;
        end
        checks++; if (strobes != 1024)   begin failures++; $display("FAIL clear_strobe_count: got %0d expected 1024", strobes); end
        checks++; if (bad != 0)          begin failures++; $display("FAIL clear_strobe_fields: got %0d bad strobes expected 0", bad); end
        checks++; if (early_ready != 0)  begin failures++; $display("FAIL clear_early_ready: got %0d cycles expected 0", early_ready); end
        checks++; if (done_edge != 1025) begin failures++; $display("FAIL clear_done_edge: got %0d expected 1025", done_edge); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_clear: got %b expected 1", req_ready); end
`else
        reset_n = 1'b1;
        #1;
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL wait_init_done: got %b expected 0", init_done); end
        @(negedge clock);
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL wait_mem_en: got %b expected 0", mem_en); end
        @(posedge clock);
        #1;
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL first_edge_init_done: got %b expected 1", init_done); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL first_edge_req_ready: got %b expected 1", req_ready); end
        checks++; if (mem_en !== 1'b0)    begin failures++; $display("FAIL first_edge_mem_en: got %b expected 0", mem_en); end
`endif
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] d;
        flush_model();
        resp_ready = 1'b1;
        d = rand_data();
        d[17:0] = 18'h2AAAA;
        drive_one(1'b1, ADDR_W'(5), 10'h001, d);
        drive_one(1'b0, ADDR_W'(5), LANES'($urandom), rand_data());
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_early_valid: got %b expected 0", resp_valid); end
        @(posedge clock);
        #1;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL wr_rd_valid_latency: got %b expected 1", resp_valid); end
        checks++; if (resp_rdata[17:0] !== 18'h2AAAA) begin failures++; $display("FAIL wr_rd_lane0: got %0h expected 2aaaa", resp_rdata[17:0]); end
        checks++; if (resp_rdata[DATA_W-1:18] !== '0) begin failures++; $display("FAIL wr_rd_masked_lanes: got %0h expected 0", resp_rdata[DATA_W-1:18]); end
        @(posedge clock);
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_drained: got %b expected 0", resp_valid); end
        flush_model();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] wd [4];
        bit                rdy [4];
        for (int i = 0; i < 4; i++) begin
            wd[i] = rand_data();
            drive_one(1'b1, ADDR_W'(i + 1), '1, wd[i]);
        end
        flush_model();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = ADDR_W'(i + 1);
            @(negedge clock);
            rdy[i] = req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdy[i] !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rdy[i]); end
        end
        checks++;
        if (obs_q.size() != 4 || fire_cyc_q.size() != 4) begin
            failures++;
            $display("FAIL b2b_resp_count: got %0d responses %0d fires expected 4", obs_q.size(), fire_cyc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_q[i] !== wd[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, obs_q[i], wd[i]); end
                checks++; if (pop_cyc_q[i] != fire_cyc_q[0] + 2 + i) begin failures++; $display("FAIL b2b_resp_cycle[%0d]: got %0d expected %0d", i, pop_cyc_q[i], fire_cyc_q[0] + 2 + i); end
            end
        end
        flush_model();
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] a [4];
        int unsigned       idx = 0;
        flush_model();
        for (int i = 0; i < 4; i++) a[i] = ADDR_W'($urandom_range(1, 8));
        resp_ready = 1'b0;
        req_write  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = (idx < 4);
            req_addr  = a[idx < 4 ? idx : 3];
            @(negedge clock);
            if (req_valid && req_ready) idx++;
            @(posedge clock);
            #1;
        end
        checks++; if (idx != 2)            begin failures++; $display("FAIL bp_fires_stalled: got %0d expected 2", idx); end
        checks++; if (req_ready !== 1'b0)  begin failures++; $display("FAIL bp_ready_low: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_resp_valid: got %b expected 1", resp_valid); end
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && !(idx == 4 && obs_q.size() == 4); c++) begin
            req_valid = (idx < 4);
            req_addr  = a[idx < 4 ? idx : 3];
            @(negedge clock);
            if (req_valid && req_ready) idx++;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        checks++;
        if (idx != 4 || obs_q.size() != 4 || exp_q.size() != 4) begin
            failures++;
            $display("FAIL bp_drain: got fires=%0d resp=%0d exp=%0d expected 4", idx, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, obs_q[i], exp_q[i]); end
            end
        end
        flush_model();
    endtask

    task automatic test_random();
        int unsigned sent = 0, data_bad = 0;
        bit          pending = 1'b0;
        flush_model();
        for (int c = 0; c < 3000 && (sent < 200 || obs_q.size() < exp_q.size()); c++) begin
            if (!pending && sent < 200 && $urandom_range(3) != 0) begin
                req_write = 1'($urandom_range(1));
                req_addr  = ADDR_W'($urandom_range(15));
                req_mask  = LANES'($urandom);
                req_wdata = rand_data();
                req_valid = 1'b1;
                pending   = 1'b1;
            end
            resp_ready = 1'($urandom_range(1));
            @(negedge clock);
            if (req_valid && req_ready) begin
                pending = 1'b0;
                sent++;
            end
            @(posedge clock);
            #1;
            if (!pending) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++; if (sent != 200) begin failures++; $display("FAIL rand_sent: got %0d expected 200", sent); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_resp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) data_bad++;
            checks++; if (data_bad != 0) begin failures++; $display("FAIL rand_resp_data: got %0d mismatching responses expected 0", data_bad); end
        end
        resp_ready = 1'b1;
        flush_model();
    endtask

    task automatic test_reset_midflight();
        bit          seen_valid = 1'b0;
        bit          done = 1'b0;
        flush_model();
        resp_ready = 1'b0;
        drive_one(1'b0, ADDR_W'(5), '0, '0);
        reset_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b0)  begin failures++; $display("FAIL rst_mid_req_ready: got %b expected 0", req_ready); end
        checks++; if (init_done !== 1'b0)  begin failures++; $display("FAIL rst_mid_init_done: got %b expected 0", init_done); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        flush_model();
`ifdef ARRAY_18_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        #1;
        checks++; if (init_done !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_wait_state: got done=%b ready=%b expected 0 0", init_done, req_ready); end
        for (int e = 0; e < 1100 && !done; e++) begin
            @(posedge clock);
            #1;
            if (resp_valid) seen_valid = 1'b1;
            done = init_done;
        end
        repeat (3) begin
            @(posedge clock);
            #1;
            if (resp_valid) seen_valid = 1'b1;
        end
        checks++; if (!done)      begin failures++; $display("FAIL rst_mid_reinit: got init_done=0 expected 1"); end
        checks++; if (seen_valid) begin failures++; $display("FAIL rst_mid_dropped: got resp_valid=1 expected 0"); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready_after: got %b expected 1", req_ready); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init_release();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
